// File: rtl/multi_fifo_arb_pkg.sv
// Shared types and constants for the multi-push FIFO arbiter.
package multi_fifo_arb_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StDrain = 2'd1,
    StClr   = 2'd2
  } flush_state_e;

  localparam int unsigned PerfCntW = 32;

endpackage

// File: rtl/rr_lane_packer.sv
// Combinational round-robin scan: grants up to `limit` valid requesters starting at rr_ptr
// and packs them onto consecutive lanes from lane 0.
module rr_lane_packer #(
  parameter int unsigned R  = 4,
  parameter int unsigned M  = 4,
  parameter int unsigned RW = 2,
  parameter int unsigned LW = 3
) (
  input  logic [R-1:0]         valid,
  input  logic [RW-1:0]        rr_ptr,
  input  logic [LW-1:0]        limit,
  output logic [R-1:0]         grant,
  output logic [M-1:0][RW-1:0] lane_src,
  output logic [M-1:0]         lane_vld,
  output logic [RW-1:0]        last
);

  always_comb begin
    int dist_r;
    int rank;
    int last_d;
    grant    = '0;
    lane_src = '0;
    lane_vld = '0;
    last     = '0;
    last_d   = 0;
    for (int r = 0; r < int'(R); r++) begin
      dist_r = (r + int'(R) - int'(rr_ptr)) % int'(R);
      // Rank = number of valid requesters ahead of r in cyclic order.
      rank = 0;
      for (int q = 0; q < int'(R); q++) begin
        if (valid[q] && (((q + int'(R) - int'(rr_ptr)) % int'(R)) < dist_r)) rank++;
      end
      if (valid[r] && (rank < int'(limit))) begin
        grant[r] = 1'b1;
        for (int l = 0; l < int'(M); l++) begin
          if (rank == l) begin
            lane_src[l] = RW'(r);
            lane_vld[l] = 1'b1;
          end
        end
        if (dist_r >= last_d) begin
          last_d = dist_r;
          last   = RW'(r);
        end
      end
    end
  end

endmodule

// File: rtl/multi_fifo_push_arb.sv
// Round-robin arbiter sharing the M push lanes of a multi-push FIFO among R requesters,
// with a flush FSM driving the FIFO clear. Optional counters under MULTI_FIFO_PUSH_ARB_PERF_EN.
module multi_fifo_push_arb
  import multi_fifo_arb_pkg::*;
#(
  parameter type         T  = logic [7:0],
  parameter int unsigned R  = 4,
  parameter int unsigned M  = 4,
  parameter int unsigned RW = (R > 1) ? $clog2(R) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [R-1:0]        req_valid,
  input  T                    req_data [R],
  output logic [R-1:0]        req_ready,
  output logic [M-1:0]        fifo_push,
  output T                    fifo_datain [M],
  input  logic                fifo_full,
  input  logic [M-1:1]        fifo_almost_full,
  input  logic                fifo_empty,
  output logic                fifo_clear,
  input  logic                flush_req,
  output logic                flush_busy,
`ifdef MULTI_FIFO_PUSH_ARB_PERF_EN
  output logic [PerfCntW-1:0] grant_cnt [R],
  output logic [PerfCntW-1:0] stall_cnt,
`endif
  output logic                flush_done
);

  localparam int unsigned LW = $clog2(M + 1);

  flush_state_e        state_q;
  logic [RW-1:0]       rr_ptr_q;
  logic [LW-1:0]       free;
  logic [LW-1:0]       limit;
  logic [R-1:0]        grant;
  logic [M-1:0][RW-1:0] lane_src;
  logic [M-1:0]        lane_vld;
  logic [RW-1:0]       last;

  // Lowest almost_full threshold that is set bounds how many entries fit this cycle.
  always_comb begin
    free = LW'(M);
    for (int i = int'(M) - 1; i >= 1; i--) begin
      if (fifo_almost_full[i]) free = LW'(i);
    end
    if (fifo_full) free = '0;
    limit = (state_q == StIdle) ? free : '0;
  end

  rr_lane_packer #(
    .R  (R),
    .M  (M),
    .RW (RW),
    .LW (LW)
  ) u_packer (
    .valid    (req_valid),
    .rr_ptr   (rr_ptr_q),
    .limit    (limit),
    .grant    (grant),
    .lane_src (lane_src),
    .lane_vld (lane_vld),
    .last     (last)
  );

  assign req_ready = grant;
  assign fifo_push = lane_vld;

  always_comb begin
    for (int l = 0; l < int'(M); l++) begin
      fifo_datain[l] = lane_vld[l] ? req_data[lane_src[l]] : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
    end else if (state_q == StClr) begin
      rr_ptr_q <= '0;
    end else if (|grant) begin
      rr_ptr_q <= RW'((int'(last) + 1) % int'(R));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      flush_busy <= 1'b0;
      fifo_clear <= 1'b0;
      flush_done <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (flush_req) begin
            state_q    <= StDrain;
            flush_busy <= 1'b1;
          end
        end
        StDrain: begin
          if (fifo_empty) begin
            state_q    <= StClr;
            fifo_clear <= 1'b1;
            flush_done <= 1'b1;
          end
        end
        StClr: begin
          state_q    <= StIdle;
          flush_busy <= 1'b0;
          fifo_clear <= 1'b0;
          flush_done <= 1'b0;
        end
        default: begin
          state_q    <= StIdle;
          flush_busy <= 1'b0;
          fifo_clear <= 1'b0;
          flush_done <= 1'b0;
        end
      endcase
    end
  end

`ifdef MULTI_FIFO_PUSH_ARB_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < int'(R); r++) grant_cnt[r] <= '0;
      stall_cnt <= '0;
    end else if (state_q == StClr) begin
      for (int r = 0; r < int'(R); r++) grant_cnt[r] <= '0;
      stall_cnt <= '0;
    end else begin
      for (int r = 0; r < int'(R); r++) begin
        if (grant[r] && (grant_cnt[r] != '1)) grant_cnt[r] <= grant_cnt[r] + 1'b1;
      end
      if ((|(req_valid & ~grant)) && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: doc/multi_fifo_push_arb.md
Name: multi_fifo_push_arb

Overview:
- Round-robin arbiter and sequencer in front of the multi-push sync FIFO.
- Shares the FIFO's M push lanes among R single-entry requesters with valid/ready handshakes.
- Packs granted entries contiguously onto lanes 0..k-1, never exceeding the free space derived from full/almost_full.
- Owns the FIFO's clear input through a flush state machine: block grants, wait for the consumer to drain, pulse clear.

Parameters:
- T, logic [7:0], entry data type (matches FIFO T).
- R, 4, number of requesters (>=1).
- M, 4, FIFO push lanes (>=2, equals FIFO M).
- RW, $clog2(R) (min 1), derived width of the round-robin pointer.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset.
- req_valid  in  R  requester r has an entry.
- req_data  in  T[R]  requester r entry.
- req_ready  out  R  entry of r accepted this cycle.
- fifo_push  out  M  to FIFO push; always contiguous from lane 0.
- fifo_datain  out  T[M]  to FIFO datain.
- fifo_full  in  1  from FIFO full.
- fifo_almost_full  in  M-1 (idx M-1:1)  from FIFO almost_full.
- fifo_empty  in  1  from FIFO empty.
- fifo_clear  out  1  to FIFO clear.
- flush_req  in  1  request a flush.
- flush_busy  out  1  flush in progress.
- flush_done  out  1  one-cycle pulse when clear is issued.

Interface fact: one clock; reset is asynchronous and active-low (clk, rst_n).

Behaviour:
- Free space, combinational:
  - free = 0 if fifo_full.
  - else free = smallest i with fifo_almost_full[i] set.
  - else free = M.
- Grant limit: limit = min(free, M); forced to 0 when state != IDLE.
- Scan: requesters in cyclic order starting at rr_ptr; the first `limit` with valid set are granted.
- Lane mapping: the n-th grant drives lane n, with fifo_push[n]=1 and fifo_datain[n]=its req_data. Unused lanes: push=0, datain='0.
- req_ready[r]=1 iff r granted. ready may depend combinationally on valid; valid must not depend on ready.
- rr_ptr:
  - Reset value 0.
  - On any grant, rr_ptr <= (index of last granted requester + 1) mod R.
  - Otherwise unchanged.
- Zero free (fifo_full): no grants, rr_ptr holds.
- Partial free (e.g. free=1 with 3 valid): only the first in rr order is granted.
- FSM states IDLE, DRAIN, CLR; reset state IDLE.
  - IDLE: flush_req -> DRAIN. Grants in that same cycle still occur; the transition is registered.
  - DRAIN: no grants; fifo_empty -> CLR.
  - CLR: fifo_clear=1 and flush_done=1 for exactly this cycle -> IDLE. rr_ptr resets to 0 on entry to IDLE from CLR.
- flush_busy = (state != IDLE).
- flush_req while busy is ignored; no queuing.
- fifo_clear and flush_done decode from registered state: no combinational path from inputs.
- Async reset mid-flush: state IDLE, rr_ptr 0, fifo_clear 0, flush_done 0. FIFO contents are not cleared by this block.
- Reset values: fifo_push 0 (no grants because valid is 0 or state != IDLE), req_ready 0, fifo_clear 0, flush_busy 0, flush_done 0.

Optional Feature:
- Macro: MULTI_FIFO_PUSH_ARB_PERF_EN.
- Defined:
  - Adds output grant_cnt [R][31:0], per-requester accepted-entry counters.
  - Each increments by 1 on its grant, saturates at 32'hFFFF_FFFF, resets to 0 on rst_n and on CLR.
  - Adds output stall_cnt [31:0], counting cycles where any valid was ungranted; same saturation and reset rules.
- Undefined: these ports and registers do not exist; behaviour is otherwise identical.

Decomposition:
- Package multi_fifo_arb_pkg: state enum (IDLE, DRAIN, CLR) and the perf counter width constant (32).
- One sub-module: rr_lane_packer (combinational). Inputs: valid vector, rr_ptr, limit. Outputs: grant vector, per-lane source index and lane-valid, and last-granted index.
- Top level holds rr_ptr, the FSM and the optional counters.

Test Plan:
- R=4, M=4, empty FIFO, all valid, rr_ptr=0 -> lanes 0..3 = req 0,1,2,3; push=4'b1111; rr_ptr->0.
- Valid=4'b1010, rr_ptr=2, free=4 -> lane0=req3, lane1=req1, push=4'b0011; next rr_ptr=2.
- almost_full[2]=1, almost_full[1]=0, full=0, all valid, rr_ptr=1 -> free=2, grants req1,req2, push=4'b0011, rr_ptr->3; with full=1 -> push=0, rr_ptr holds.
- flush_req with FIFO holding 5 entries -> busy next cycle, ready=0 throughout DRAIN. Consumer pops to empty -> one cycle later fifo_clear=1 and flush_done=1 for one cycle, then IDLE with rr_ptr=0.
- Assert rst_n low during DRAIN -> immediately flush_busy=0, fifo_clear=0; after release, grants resume from rr_ptr=0.
- PERF_EN build: req2 granted 3 times, then 2 stalled cycles -> grant_cnt[2]=3, stall_cnt=2; both reach 0 after a flush.
